// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Purpose  : Stall/flush controller for a 5-stage RV32 pipeline. Drives the
//            PC/F/D/E/M register enables and the D/E/W bubble controls.
//            Handles load-use hazards with an x0 exemption, branch flushes and
//            a variable-latency data-memory handshake with a wait timeout.
// Config   : PERF_CNT_EN - when defined, builds saturating perf counters
//            (load-use stalls, memory stalls, branch flushes). When undefined,
//            the cnt_* ports are tied to zero and no counter flops exist.
// Ports    :
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   ResultSrc_E        E-stage result select (2'b01 = load)
//   RegWrite_E, Rd_E   E-stage register write enable / destination
//   Rs1_D, Rs2_D       D-stage source registers
//   PCSrc_E            taken branch/jump resolved in E
//   MemReq_M, mem_ack  M-stage memory request / memory completion
//   valid_PC..valid_M  register enables
//   flash_D, flash_E   bubble insertion into F/D and D/E
//   flash_W            suppress W-stage write/retire
//   mem_busy           memory FSM is in WAIT
//   mem_timeout        sticky memory-timeout flag (cleared by reset only)
//   cnt_ld/mem/fl      perf counters
// Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int REG_AW  = 5,
    parameter int MEM_TMO = 15,
    parameter int TMO_W   = 4,
    parameter int CNT_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        ResultSrc_E,
    input  logic              RegWrite_E,
    input  logic [REG_AW-1:0] Rs1_D,
    input  logic [REG_AW-1:0] Rs2_D,
    input  logic [REG_AW-1:0] Rd_E,
    input  logic              PCSrc_E,
    input  logic              MemReq_M,
    input  logic              mem_ack,
    output logic              valid_PC,
    output logic              valid_F,
    output logic              valid_D,
    output logic              valid_E,
    output logic              valid_M,
    output logic              flash_D,
    output logic              flash_E,
    output logic              flash_W,
    output logic              mem_busy,
    output logic              mem_timeout,
    output logic [CNT_W-1:0]  cnt_ld,
    output logic [CNT_W-1:0]  cnt_mem,
    output logic [CNT_W-1:0]  cnt_fl
);

    localparam logic [0:0]       S_IDLE    = 1'b0;
    localparam logic [0:0]       S_WAIT    = 1'b1;
    localparam logic [TMO_W-1:0] c_mem_tmo = TMO_W'(MEM_TMO);
    localparam logic [TMO_W-1:0] c_one     = TMO_W'(1);

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [TMO_W-1:0] r_wcnt;
    logic [TMO_W-1:0] w_wcnt_nxt;
    logic             r_timeout;
    logic             w_timeout_nxt;
    logic             w_mem_wait;
    logic             w_rdy_m;
    logic             w_lwstall;

    // Load-use hazard: a load in E feeding a D-stage source. Writes to x0
    // never create a real dependency, so they are exempt.
    assign w_lwstall = (ResultSrc_E == 2'b01) && RegWrite_E && (Rd_E != '0) &&
                       ((Rs1_D == Rd_E) || (Rs2_D == Rd_E));

    assign w_rdy_m = ~w_mem_wait;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_wcnt    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_wcnt    <= w_wcnt_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. mem_wait is produced here because it depends on
    // the same transition conditions: the cycle that leaves WAIT (ack or
    // timeout) is already a released cycle.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_wcnt_nxt    = r_wcnt;
        w_timeout_nxt = r_timeout;
        w_mem_wait    = 1'b0;
        case (r_state)
            S_IDLE: begin
                // A same-cycle ack completes with zero stall; an ack with
                // no request is simply ignored.
                if (MemReq_M && !mem_ack) begin
                    w_state_nxt = S_WAIT;
                    w_wcnt_nxt  = c_one;
                    w_mem_wait  = 1'b1;
                end
            end
            S_WAIT: begin
                if (mem_ack) begin
                    w_state_nxt = S_IDLE;
                    w_wcnt_nxt  = '0;
                end else if (r_wcnt == c_mem_tmo) begin
                    // Give up: release the pipeline, flag the error.
                    w_state_nxt   = S_IDLE;
                    w_wcnt_nxt    = '0;
                    w_timeout_nxt = 1'b1;
                end else begin
                    w_wcnt_nxt = r_wcnt + c_one;
                    w_mem_wait = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_wcnt_nxt  = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic. A memory wait freezes everything and masks flushes, so
    // a pending branch or load-use bubble takes effect on release. A branch
    // beats a load-use stall: the PC must load the target.
    // ------------------------------------------------------------------
    always_comb begin
        valid_M     = w_rdy_m;
        valid_E     = w_rdy_m;
        valid_D     = w_rdy_m;
        valid_PC    = w_rdy_m && (!w_lwstall || PCSrc_E);
        valid_F     = w_rdy_m && (!w_lwstall || PCSrc_E);
        flash_D     = w_rdy_m && PCSrc_E;
        flash_E     = w_rdy_m && (PCSrc_E || w_lwstall);
        flash_W     = w_mem_wait;
        mem_busy    = (r_state == S_WAIT);
        mem_timeout = r_timeout;
    end

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] r_cnt_ld;
    logic [CNT_W-1:0] r_cnt_mem;
    logic [CNT_W-1:0] r_cnt_fl;
    logic             w_inc_ld;
    logic             w_inc_fl;

    // Only stalls that actually hold the front end count as load-use cycles.
    assign w_inc_ld = w_lwstall && w_rdy_m && !PCSrc_E;
    assign w_inc_fl = w_rdy_m && PCSrc_E;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt_ld  <= '0;
            r_cnt_mem <= '0;
            r_cnt_fl  <= '0;
        end else begin
            if (w_inc_ld && !(&r_cnt_ld))
                r_cnt_ld <= r_cnt_ld + CNT_W'(1);
            if (w_mem_wait && !(&r_cnt_mem))
                r_cnt_mem <= r_cnt_mem + CNT_W'(1);
            if (w_inc_fl && !(&r_cnt_fl))
                r_cnt_fl <= r_cnt_fl + CNT_W'(1);
        end
    end

    assign cnt_ld  = r_cnt_ld;
    assign cnt_mem = r_cnt_mem;
    assign cnt_fl  = r_cnt_fl;
`else
    assign cnt_ld  = '0;
    assign cnt_mem = '0;
    assign cnt_fl  = '0;
`endif

endmodule
`default_nettype wire
